// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_pkg
// Description : Shared state encodings and constants for the program-counter
//               generator and its redirect buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_gen_pkg;

  // FSM state type; encodings kept as plain constants so older code that
  // compares raw 2-bit values keeps working.
  typedef logic [1:0] pc_state_t;

  localparam pc_state_t PC_BOOT  = 2'd0;
  localparam pc_state_t PC_RUN   = 2'd1;
  localparam pc_state_t PC_PEND  = 2'd2;
  localparam pc_state_t PC_FAULT = 2'd3;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  localparam logic        Stop        = 1'b1;
  localparam logic        NotStop     = 1'b0;

  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;

endpackage : pc_gen_pkg
`default_nettype wire

// File: rtl/pc_redirect_buf.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_buf
// Description : Holds a redirect target that arrived while the PC was stalled
//               and owns the control-flow epoch counter.
//               load    : capture target, mark pending, advance epoch
//               bump    : advance epoch only (redirect applied directly)
//               consume : pending target has been moved into the PC
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned EPOCH_WIDTH = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   load_in,
  input  logic                   bump_in,
  input  logic                   consume_in,
  input  logic [ADDR_WIDTH-1:0]  target_in,
  output logic [ADDR_WIDTH-1:0]  pend_addr_out,
  output logic                   pend_valid_out,
  output logic [EPOCH_WIDTH-1:0] epoch_out
);

  logic [ADDR_WIDTH-1:0]  pend_q, pend_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;

  // Next-state: a load overrides any earlier pending target (last one wins);
  // every load or bump advances the epoch exactly once, wrapping naturally.
  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    epoch_d      = epoch_q;
    if (consume_in) begin
      pend_valid_d = 1'b0;
    end
    if (load_in) begin
      pend_d       = target_in;
      pend_valid_d = 1'b1;
    end
    if (load_in || bump_in) begin
      epoch_d = epoch_q + EPOCH_WIDTH'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pend_q       <= ADDR_WIDTH'(ZeroWord);
      pend_valid_q <= 1'b0;
      epoch_q      <= '0;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      epoch_q      <= epoch_d;
    end
  end

  assign pend_addr_out  = pend_q;
  assign pend_valid_out = pend_valid_q;
  assign epoch_out      = epoch_q;

endmodule : pc_redirect_buf
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Program-counter generator feeding the IF stage over a
//               valid/ready handshake. Buffers redirects across stalls, tags
//               control flow with an epoch and traps misaligned targets.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = ADDR_WIDTH'(32'h0000_0000),
  parameter int unsigned            INST_BYTES   = 4,
  parameter int unsigned            STALL_WIDTH  = 6,
  parameter int unsigned            EPOCH_WIDTH  = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic [STALL_WIDTH-1:0] stall_in,
  input  logic                   redirect_valid_in,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr_in,
  input  logic                   fetch_ready_in,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic                   pc_valid_out,
  output logic [EPOCH_WIDTH-1:0] epoch_out,
  output logic                   ce_out,
  output logic                   misalign_out
);

  // INST_BYTES is a power of two, so alignment is a low-bit mask test.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INST_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INST_BYTES);

  pc_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic                  ce_q, ce_d;
  logic                  misalign_q, misalign_d;

  logic                  buf_load, buf_bump, buf_consume;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic                  pend_valid;
  logic                  stalled, aligned, acc;

  // Only bit 0 of the stall vector concerns the PC; the rest is folded into
  // a sink so the full vector stays on the port for the pipeline's benefit.
  logic unused_stall;
  assign unused_stall = ^stall_in;

  assign stalled = (stall_in[0] == Stop);
  assign aligned = (redirect_addr_in & ALIGN_MASK) == ADDR_WIDTH'(ZeroWord);
  assign acc     = valid_q & fetch_ready_in & ~stalled;

  pc_redirect_buf #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .EPOCH_WIDTH (EPOCH_WIDTH)
  ) u_redirect_buf (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .load_in        (buf_load),
    .bump_in        (buf_bump),
    .consume_in     (buf_consume),
    .target_in      (redirect_addr_in),
    .pend_addr_out  (pend_addr),
    .pend_valid_out (pend_valid),
    .epoch_out      (epoch_out)
  );

  // Next-state logic; with rdy_in low nothing changes and redirects are
  // ignored, so every strobe into the buffer is also gated by rdy_in.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    ce_d        = ce_q;
    misalign_d  = misalign_q;
    buf_load    = 1'b0;
    buf_bump    = 1'b0;
    buf_consume = 1'b0;

    if (rdy_in) begin
      case (state_q)
        // BOOT behaves as RUN for redirects; otherwise it just turns fetch on
        // at the reset vector without stepping.
        PC_BOOT, PC_RUN: begin
          ce_d = ChipEnable;
          if (redirect_valid_in && !aligned) begin
            pc_d       = redirect_addr_in;
            valid_d    = 1'b0;
            misalign_d = 1'b1;
            buf_bump   = 1'b1;
            state_d    = PC_FAULT;
          end else if (redirect_valid_in && !stalled) begin
            pc_d     = redirect_addr_in;
            valid_d  = 1'b1;
            buf_bump = 1'b1;
            state_d  = PC_RUN;
          end else if (redirect_valid_in) begin
            buf_load = 1'b1;
            valid_d  = 1'b0;
            state_d  = PC_PEND;
          end else if (state_q == PC_BOOT) begin
            valid_d = 1'b1;
            state_d = PC_RUN;
          end else if (acc) begin
            pc_d = pc_q + STEP;
          end
        end

        // Waiting for the stall to clear; newer redirects replace the target.
        PC_PEND: begin
          if (redirect_valid_in && !aligned) begin
            pc_d       = redirect_addr_in;
            valid_d    = 1'b0;
            misalign_d = 1'b1;
            buf_bump   = 1'b1;
            state_d    = PC_FAULT;
          end else if (redirect_valid_in) begin
            buf_load = 1'b1;
          end else if (!stalled && pend_valid) begin
            pc_d        = pend_addr;
            valid_d     = 1'b1;
            buf_consume = 1'b1;
            state_d     = PC_RUN;
          end
        end

        // Fetch is halted until software supplies an aligned target. A further
        // misaligned redirect replaces the reported bad address.
        PC_FAULT: begin
          valid_d    = 1'b0;
          misalign_d = 1'b1;
          if (redirect_valid_in && aligned) begin
            misalign_d = 1'b0;
            if (!stalled) begin
              pc_d     = redirect_addr_in;
              valid_d  = 1'b1;
              buf_bump = 1'b1;
              state_d  = PC_RUN;
            end else begin
              buf_load = 1'b1;
              state_d  = PC_PEND;
            end
          end else if (redirect_valid_in) begin
            pc_d     = redirect_addr_in;
            buf_bump = 1'b1;
          end
        end

        default: begin
          state_d = PC_BOOT;
        end
      endcase
    end
  end

  // Control and address registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= PC_BOOT;
      pc_q       <= RESET_VECTOR;
      valid_q    <= 1'b0;
      ce_q       <= ChipDisable;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      ce_q       <= ce_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_out       = pc_q;
  assign pc_valid_out = valid_q;
  assign ce_out       = ce_q;
  assign misalign_out = misalign_q;

endmodule : pc_gen
`default_nettype wire
